multi_issue_buffer: RTL

MULTI_ISSUE_BUFFER -- requirements
Module: multi_issue_buffer

---
 rtl/ariane_pkg.sv | 26 ++
 rtl/multi_issue_buffer_if.sv | 38 +++
 rtl/lzc.sv | 27 ++
 rtl/multi_issue_buffer.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/ariane_pkg.sv
// Shared types for the multi-issue buffer: instruction payload, storage entry,
// FSM state and a protocol helper.
package ariane_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [7:0]  op;
        logic [4:0]  rd;
    } scoreboard_entry_t;

    typedef struct packed {
        scoreboard_entry_t sbe;
        logic              is_ctrl_flow;
    } mib_entry_t;

    typedef enum logic {
        IDLE,
        WAIT_RESOLVE
    } mib_state_e;

    // A valid/ack vector is legal only if its set bits form a run starting at bit 0.
    function automatic logic is_prefix(input logic [3:0] v);
        return (v & (v + 4'd1)) == 4'd0;
    endfunction

endpackage

// File: rtl/multi_issue_buffer_if.sv
// Handshake bundle between decode, the multi-issue buffer and the issue stage.
// slave is the buffer side, master the surrounding pipeline.
interface multi_issue_buffer_if
    import ariane_pkg::*;
#(
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned NR_IN_PORTS  = 2,
    parameter int unsigned NR_OUT_PORTS = 2
);
    localparam int unsigned USAGE_W = $clog2(DEPTH) + 1;

    logic                                 flush_i;
    logic                                 flush_unissued_instr_i;
    scoreboard_entry_t [NR_IN_PORTS-1:0]  decoded_instr_i;
    logic [NR_IN_PORTS-1:0]               decoded_instr_valid_i;
    logic [NR_IN_PORTS-1:0]               is_ctrl_flow_i;
    logic [NR_IN_PORTS-1:0]               decoded_instr_ack_o;
    scoreboard_entry_t [NR_OUT_PORTS-1:0] issue_instr_o;
    logic [NR_OUT_PORTS-1:0]              issue_instr_valid_o;
    logic [NR_OUT_PORTS-1:0]              issue_ack_i;
    logic                                 resolve_branch_i;
    logic [USAGE_W-1:0]                   usage_o;
    logic                                 full_o;
    logic                                 empty_o;

    modport slave (
        input  flush_i, flush_unissued_instr_i, decoded_instr_i, decoded_instr_valid_i,
               is_ctrl_flow_i, issue_ack_i, resolve_branch_i,
        output decoded_instr_ack_o, issue_instr_o, issue_instr_valid_o, usage_o, full_o, empty_o
    );

    modport master (
        output flush_i, flush_unissued_instr_i, decoded_instr_i, decoded_instr_valid_i,
               is_ctrl_flow_i, issue_ack_i, resolve_branch_i,
        input  decoded_instr_ack_o, issue_instr_o, issue_instr_valid_o, usage_o, full_o, empty_o
    );

endinterface

// File: rtl/lzc.sv
// Leading/trailing zero counter. MODE=0 counts trailing zeros, MODE=1 leading zeros;
// empty_o flags an all-zero input (cnt_o is then 0).
module lzc #(
    parameter int unsigned WIDTH     = 2,
    parameter bit          MODE      = 1'b0,
    parameter int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0]     in_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 empty_o
);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        cnt_o = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (MODE == 1'b0) begin
                if (in_i[i]) cnt_o = CNT_WIDTH'(i);
            end else begin
                if (in_i[WIDTH-1-i]) cnt_o = CNT_WIDTH'(i);
            end
        end
    end

    assign empty_o = ~|in_i;

endmodule

// File: rtl/multi_issue_buffer.sv
// Circular issue buffer: accepts up to NR_IN_PORTS decoded instructions per cycle and
// issues up to NR_OUT_PORTS in order, stalling behind control flow until it resolves.
// Define MULTI_ISSUE_BUFFER_BYPASS_EN to let valid inputs join the issue window directly.
module multi_issue_buffer
    import ariane_pkg::*;
#(
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned NR_IN_PORTS  = 2,
    parameter int unsigned NR_OUT_PORTS = 2
) (
    input logic                 clk_i,
    input logic                 rst_i,
    multi_issue_buffer_if.slave bus
);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
    localparam int unsigned IN_CW  = (NR_IN_PORTS > 1) ? $clog2(NR_IN_PORTS) : 1;
    localparam int unsigned OUT_CW = (NR_OUT_PORTS > 1) ? $clog2(NR_OUT_PORTS) : 1;

    mib_state_e        state_q, state_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, full_d, empty_q, empty_d;
    mib_entry_t        mem_q [DEPTH];
    mib_entry_t        mem_d [DEPTH];

    mib_entry_t [NR_OUT_PORTS-1:0] win;
    logic [NR_OUT_PORTS-1:0]       win_present, win_cf, issue_valid;
    logic [NR_IN_PORTS-1:0]        ack;
    logic [OUT_CW-1:0]             gate_cnt, deq_cnt;
    logic [IN_CW-1:0]              enq_cnt;
    logic                          gate_empty, deq_empty, enq_empty;
    logic                          flush_any;
    int                            n_deq, n_ack, n_byp;

    assign flush_any = bus.flush_i | bus.flush_unissued_instr_i;

    always_comb begin
        for (int j = 0; j < NR_OUT_PORTS; j++) begin
            win[j]         = mem_q[rptr_q + PTR_W'(j)];
            win_present[j] = int'(count_q) > j;
`ifdef MULTI_ISSUE_BUFFER_BYPASS_EN
            for (int k = 0; k < NR_IN_PORTS; k++) begin
                if (!flush_any && int'(count_q) + k == j) begin
                    win[j]         = '{sbe: bus.decoded_instr_i[k], is_ctrl_flow: bus.is_ctrl_flow_i[k]};
                    win_present[j] = bus.decoded_instr_valid_i[k];
                end
            end
`endif
            win_cf[j] = win_present[j] & win[j].is_ctrl_flow;
        end
    end

    // First control-flow slot in the window is the last one allowed to issue.
    lzc #(.WIDTH(NR_OUT_PORTS), .MODE(1'b0)) i_gate_lzc (
        .in_i(win_cf), .cnt_o(gate_cnt), .empty_o(gate_empty)
    );

    always_comb begin
        issue_valid = '0;
        for (int j = 0; j < NR_OUT_PORTS; j++) begin
            issue_valid[j] = !rst_i && state_q == IDLE && win_present[j]
                             && (gate_empty || j <= int'(gate_cnt));
            bus.issue_instr_o[j] = win[j].sbe;
        end
    end

    assign bus.issue_instr_valid_o = issue_valid;

    lzc #(.WIDTH(NR_OUT_PORTS), .MODE(1'b0)) i_deq_lzc (
        .in_i(~bus.issue_ack_i), .cnt_o(deq_cnt), .empty_o(deq_empty)
    );

    assign n_deq = deq_empty ? int'(NR_OUT_PORTS) : int'(deq_cnt);

`ifdef MULTI_ISSUE_BUFFER_BYPASS_EN
    // Inputs consumed straight from the window never occupy a slot.
    assign n_byp = (n_deq > int'(count_q)) ? n_deq - int'(count_q) : 0;
`else
    assign n_byp = 0;
`endif

    // Space comes from the registered count only, so freed slots are reused next cycle.
    always_comb begin
        ack = '0;
        for (int k = 0; k < NR_IN_PORTS; k++) begin
            if (bus.decoded_instr_valid_i[k] && !flush_any && !rst_i) begin
                ack[k] = (k < n_byp) || (k - n_byp < int'(DEPTH) - int'(count_q));
            end
        end
    end

    assign bus.decoded_instr_ack_o = ack;

    lzc #(.WIDTH(NR_IN_PORTS), .MODE(1'b0)) i_enq_lzc (
        .in_i(~ack), .cnt_o(enq_cnt), .empty_o(enq_empty)
    );

    assign n_ack = enq_empty ? int'(NR_IN_PORTS) : int'(enq_cnt);

    always_comb begin
        mem_d = mem_q;
        for (int k = 0; k < NR_IN_PORTS; k++) begin
            if (ack[k] && k >= n_byp) begin
                mem_d[wptr_q + PTR_W'(k - n_byp)] =
                    '{sbe: bus.decoded_instr_i[k], is_ctrl_flow: bus.is_ctrl_flow_i[k]};
            end
        end
        wptr_d  = wptr_q + PTR_W'(n_ack - n_byp);
        rptr_d  = rptr_q + PTR_W'(n_deq - n_byp);
        count_d = CNT_W'(int'(count_q) + n_ack - n_deq);

        state_d = state_q;
        case (state_q)
            IDLE:         if (|(bus.issue_ack_i & issue_valid & win_cf)) state_d = WAIT_RESOLVE;
            WAIT_RESOLVE: if (bus.resolve_branch_i) state_d = IDLE;
            default:      state_d = IDLE;
        endcase

        if (flush_any) begin
            count_d = '0;
            rptr_d  = wptr_q;
        end
        if (bus.flush_i) state_d = IDLE;

        full_d  = count_d == CNT_W'(DEPTH);
        empty_d = count_d == '0;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            state_q <= state_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    // NOTE: storage is left unreset; count gates every read, so stale contents are never seen.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign bus.usage_o = count_q;
    assign bus.full_o  = full_q;
    assign bus.empty_o = empty_q;

    valid_prefix_a: assert property (@(posedge clk_i) disable iff (rst_i)
        is_prefix(4'(bus.decoded_instr_valid_i)));
    ack_prefix_a: assert property (@(posedge clk_i) disable iff (rst_i)
        is_prefix(4'(bus.issue_ack_i)) && ((bus.issue_ack_i & ~issue_valid) == '0));

endmodule
